// File: rtl/angle_fold_seq_pkg.sv
// Shared constants, state encoding and quadrant codes for the sequential angle folder.
package angle_fold_seq_pkg;

  localparam logic [31:0] FP_HALF_PI      = 32'h3fc90fdb;
  localparam logic [31:0] FP_NEG_HALF_PI  = 32'hbfc90fdb;
  localparam logic [31:0] FP_NEG_PI       = 32'hc0490fdb;
  localparam logic [31:0] FP_NEG_3HALF_PI = 32'hc096cbe4;
  localparam logic [31:0] FP_ZERO         = 32'h00000000;

  localparam logic [1:0] QUAD_0 = 2'd0;
  localparam logic [1:0] QUAD_1 = 2'd1;
  localparam logic [1:0] QUAD_2 = 2'd2;
  localparam logic [1:0] QUAD_3 = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S90  = 3'd1,
    S180 = 3'd2,
    S270 = 3'd3,
    FIX  = 3'd4,
    DONE = 3'd5
  } state_t;

  // States in which the shared adder result is being consumed.
  function automatic logic is_add_state(input state_t s);
    return (s == S90) || (s == S180) || (s == S270) || (s == FIX);
  endfunction

endpackage

// File: rtl/angle_fold_seq_fadder.sv
// Combinational fp32 adder, round-to-nearest-even, gradual underflow; Inf/NaN passed through.
module fadder
  import angle_fold_seq_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  logic        a_big;
  logic [31:0] x;
  logic [31:0] y;
  logic [7:0]  ex;
  logic [7:0]  ey;
  logic [7:0]  exe;
  logic [7:0]  eye;
  logic [7:0]  d;
  logic [4:0]  dd;
  logic [23:0] mx;
  logic [23:0] my;
  logic [53:0] tmp;
  logic        sticky;
  logic [26:0] my_al;
  logic        eff_sub;
  logic [27:0] s28;
  logic [4:0]  lz;
  logic [7:0]  lim;
  logic [4:0]  sh;
  logic [26:0] norm;
  logic [8:0]  e_n;
  logic [8:0]  e_fld;
  logic        up;
  logic [30:0] mag;

  // x is the operand of larger magnitude so the subtraction never goes negative.
  assign a_big = a[30:0] >= b[30:0];
  assign x     = a_big ? a : b;
  assign y     = a_big ? b : a;
  assign ex    = x[30:23];
  assign ey    = y[30:23];
  assign exe   = (ex == 8'd0) ? 8'd1 : ex;
  assign eye   = (ey == 8'd0) ? 8'd1 : ey;
  assign mx    = {ex != 8'd0, x[22:0]};
  assign my    = {ey != 8'd0, y[22:0]};

  assign d      = exe - eye;
  assign dd     = (d > 8'd27) ? 5'd27 : d[4:0];
  assign tmp    = {my, 3'b000, 27'b0} >> dd;
  assign sticky = |tmp[26:0];
  assign my_al  = tmp[53:27] | {26'b0, sticky};

  assign eff_sub = x[31] ^ y[31];
  assign s28 = eff_sub ? ({1'b0, mx, 3'b000} - {1'b0, my_al})
                       : ({1'b0, mx, 3'b000} + {1'b0, my_al});

  always_comb begin
    lz = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s28[i]) lz = 5'(26 - i);
    end
  end

  // Left shift is capped so the exponent stops at 1 and the result goes subnormal.
  assign lim = exe - 8'd1;
  assign sh  = ({3'b0, lz} > lim) ? lim[4:0] : lz;

  always_comb begin
    if (s28[27]) begin
      norm = {s28[27:2], s28[1] | s28[0]};
      e_n  = {1'b0, exe} + 9'd1;
    end else begin
      norm = s28[26:0] << sh;
      e_n  = {1'b0, exe} - {4'b0, sh};
    end
  end

  assign e_fld = norm[26] ? e_n : 9'd0;
  assign up    = norm[2] & (norm[1] | norm[0] | norm[3]);
  // Rounding carry ripples into the exponent field, covering subnormal->normal and overflow.
  assign mag   = {e_fld[7:0], norm[25:3]} + {30'b0, up};

  always_comb begin
    if (ex == 8'hff) begin
      sum = (ey == 8'hff && eff_sub && x[22:0] == 23'd0 && y[22:0] == 23'd0) ? 32'h7fc00000 : x;
    end else if (s28 == 28'd0) begin
      sum = {x[31] & y[31], 31'b0};
    end else if (e_fld >= 9'd255) begin
      sum = {x[31], 8'hff, 23'b0};
    end else begin
      sum = {x[31], mag};
    end
  end

endmodule

// File: rtl/angle_fold_seq.sv
// Folds an fp32 angle into its first-quadrant equivalent plus quadrant code, reusing one
// fadder over several states; one transaction in flight, result held until out_ready.
module angle_fold_seq #(
  parameter int ADD_WAIT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] angle_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] angle_out,
  output logic [1:0]  quadrant,
  output logic        busy
);
  import angle_fold_seq_pkg::*;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] a_r;
  logic [30:0] r90;
  logic [31:0] r180;
  logic [31:0] fa;
  logic [31:0] fb;
  logic [31:0] fa_nxt;
  logic [31:0] fb_nxt;
  logic [1:0]  q_r;
  logic [1:0]  q_nxt;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] sum;
  logic        add_done;
  logic        ld_a;
  logic        ld_r90;
  logic        ld_r180;
  logic        ld_out;
  logic [31:0] out_nxt;
  logic [1:0]  oq_nxt;

  generate
    if (ADD_WAIT == 0) begin : g_nowait
      assign add_done = 1'b1;
    end else begin : g_wait
      localparam int CW = $clog2(ADD_WAIT + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt <= '0;
        end else if (state_nxt != state) begin
          cnt <= '0;
        end else if (is_add_state(state)) begin
          cnt <= cnt + 1'b1;
        end
      end

      assign add_done = (cnt == CW'(ADD_WAIT));
    end
  endgenerate

  // Operands depend only on registered state, so no path loops back through the adder.
  always_comb begin
    op_a = a_r;
    op_b = FP_NEG_HALF_PI;
    case (state)
      S180: op_b = FP_NEG_PI;
      S270: op_b = FP_NEG_3HALF_PI;
      FIX: begin
        op_a = fa;
        op_b = fb;
      end
      default: ;
    endcase
  end

  fadder u_fadder (
    .a   (op_a),
    .b   (op_b),
    .sum (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fa_nxt    = fa;
    fb_nxt    = fb;
    q_nxt     = q_r;
    ld_a      = 1'b0;
    ld_r90    = 1'b0;
    ld_r180   = 1'b0;
    ld_out    = 1'b0;
    out_nxt   = angle_out;
    oq_nxt    = quadrant;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          ld_a      = 1'b1;
          state_nxt = S90;
        end
      end
      S90: begin
        if (add_done) begin
          ld_r90 = 1'b1;
          if (sum[31]) begin
            ld_out    = 1'b1;
            out_nxt   = a_r;
            oq_nxt    = QUAD_0;
            state_nxt = DONE;
          end else begin
            state_nxt = S180;
          end
        end
      end
      S180: begin
        if (add_done) begin
          ld_r180 = 1'b1;
          if (sum[31]) begin
            q_nxt     = QUAD_1;
            fa_nxt    = FP_HALF_PI;
            fb_nxt    = {1'b1, r90};
            state_nxt = FIX;
          end else begin
            state_nxt = S270;
          end
        end
      end
      S270: begin
        if (add_done) begin
          // Quadrant 2 still goes through the adder (+0) so zero/normalisation match the chain.
          if (sum[31]) begin
            q_nxt  = QUAD_2;
            fa_nxt = FP_ZERO;
            fb_nxt = r180;
          end else begin
            q_nxt  = QUAD_3;
            fa_nxt = FP_HALF_PI;
            fb_nxt = {1'b1, sum[30:0]};
          end
          state_nxt = FIX;
        end
      end
      FIX: begin
        if (add_done) begin
          ld_out    = 1'b1;
          out_nxt   = sum;
          oq_nxt    = q_r;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r       <= '0;
      r90       <= '0;
      r180      <= '0;
      fa        <= '0;
      fb        <= '0;
      q_r       <= '0;
      angle_out <= '0;
      quadrant  <= '0;
    end else begin
      if (ld_a)    a_r  <= angle_in;
      if (ld_r90)  r90  <= sum[30:0];
      if (ld_r180) r180 <= sum;
      fa  <= fa_nxt;
      fb  <= fb_nxt;
      q_r <= q_nxt;
      if (ld_out) begin
        angle_out <= out_nxt;
        quadrant  <= oq_nxt;
      end
    end
  end

  assign in_ready  = (state == IDLE) && !rst;
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_angle_fold_seq.sv
// Directed-vector and random checks of angle_fold_seq against an fp32 chain built on real arithmetic.
module tb_angle_fold_seq;

  localparam logic [31:0] T_HALF_PI      = 32'h3fc90fdb;
  localparam logic [31:0] T_NEG_HALF_PI  = 32'hbfc90fdb;
  localparam logic [31:0] T_NEG_PI       = 32'hc0490fdb;
  localparam logic [31:0] T_NEG_3HALF_PI = 32'hc096cbe4;

  typedef struct {
    logic [31:0] ang;
    logic [31:0] res;
    logic [1:0]  q;
    int          lat;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [31:0] angle_in0, angle_out0;
  logic [1:0]  quadrant0;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2;
  logic [31:0] angle_in2, angle_out2;
  logic [1:0]  quadrant2;

  int n_chk = 0;
  int n_pass = 0;

  angle_fold_seq #(.ADD_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0), .angle_in(angle_in0),
    .out_valid(out_valid0), .out_ready(out_ready0), .angle_out(angle_out0),
    .quadrant(quadrant0), .busy(busy0)
  );

  angle_fold_seq #(.ADD_WAIT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .angle_in(angle_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .angle_out(angle_out2),
    .quadrant(quadrant2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic real f2r(input logic [31:0] f);
    logic [63:0] dbl;
    if (f[30:23] == 8'd0) return (f[31] ? -1.0 : 1.0) * real'(f[22:0]) * (2.0 ** (-149));
    dbl = {f[31], 11'(int'(f[30:23]) + 896), f[22:0], 29'b0};
    return $bitstoreal(dbl);
  endfunction

  // Double holds the exact-or-correctly-rounded sum; one more RNE step gives the fp32 sum.
  function automatic logic [31:0] r2f(input real r);
    logic [63:0] dbl;
    int          e;
    logic [30:0] m;
    logic        up;
    dbl = $realtobits(r);
    e = int'(dbl[62:52]) - 896;
    if (dbl[62:52] == 11'd0 || e <= 0) return {dbl[63], 31'b0};
    m  = {e[7:0], dbl[51:29]};
    up = dbl[28] & ((|dbl[27:0]) | dbl[29]);
    m  = m + {30'b0, up};
    return {dbl[63], m};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return r2f(f2r(a) + f2r(b));
  endfunction

  task automatic fold(input logic [31:0] a, output logic [31:0] res, output logic [1:0] q,
                      output int nadd);
    logic [31:0] s, r90, r180;
    s = fadd(a, T_NEG_HALF_PI);
    if (s[31]) begin
      res = a; q = 2'd0; nadd = 1;
      return;
    end
    r90 = s;
    s = fadd(a, T_NEG_PI);
    if (s[31]) begin
      res = fadd(T_HALF_PI, {1'b1, r90[30:0]}); q = 2'd1; nadd = 3;
      return;
    end
    r180 = s;
    s = fadd(a, T_NEG_3HALF_PI);
    nadd = 4;
    if (s[31]) begin
      res = fadd(32'h0, r180); q = 2'd2;
    end else begin
      res = fadd(T_HALF_PI, {1'b1, s[30:0]}); q = 2'd3;
    end
  endtask

  // Called #1 after an edge with dut0 idle.
  task automatic run0(input vec_t v, input string tag);
    int lat;
    angle_in0 = v.ang;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    lat = 1;
    chk({tag, " in_ready_low"}, 32'(in_ready0), 32'd0);
    while (!out_valid0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " latency"}, lat, v.lat);
    chk({tag, " angle_out"}, angle_out0, v.res);
    chk({tag, " quadrant"}, 32'(quadrant0), 32'(v.q));
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    chk({tag, " out_valid_drop"}, 32'(out_valid0), 32'd0);
    chk({tag, " in_ready_back"}, 32'(in_ready0), 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tbl[9];
    vec_t        v;
    logic [31:0] exp_res;
    logic [1:0]  exp_q;
    int          nadd;
    int          lat;
    real         rr;

    tbl[0] = '{32'h3F000000, 32'h3F000000, 2'd0, 2};
    tbl[1] = '{32'h40000000, 32'h3F921FB6, 2'd1, 4};
    tbl[2] = '{32'h40800000, 32'h3F5BC094, 2'd2, 5};
    tbl[3] = '{32'h40A00000, 32'h3FA43F6B, 2'd3, 5};
    tbl[4] = '{32'hBF800000, 32'hBF800000, 2'd0, 2};
    tbl[5] = '{32'h3FC90FDB, 32'h3FC90FDB, 2'd1, 4};
    tbl[6] = '{32'h40490FDB, 32'h00000000, 2'd2, 5};
    tbl[7] = '{32'h4096CBE4, 32'h3FC90FDB, 2'd3, 5};
    tbl[8] = '{32'h40C00000, 32'h3E90FDAC, 2'd3, 5};

    rst = 1'b1;
    in_valid0 = 1'b0; out_ready0 = 1'b0; angle_in0 = '0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; angle_in2 = '0;
    #2;
    chk("rst out_valid", 32'(out_valid0), 32'd0);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst in_ready", 32'(in_ready0), 32'd0);
    chk("rst angle_out", angle_out0, 32'd0);
    chk("rst quadrant", 32'(quadrant0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst in_ready", 32'(in_ready0), 32'd1);
    chk("post-rst in_ready w2", 32'(in_ready2), 32'd1);

    for (int i = 0; i < 9; i++) begin
      run0(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset pulse while in S180 aborts immediately.
    angle_in0 = 32'h40800000;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    @(posedge clk); #1;
    chk("mid busy", 32'(busy0), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort out_valid", 32'(out_valid0), 32'd0);
    chk("abort busy", 32'(busy0), 32'd0);
    chk("abort in_ready", 32'(in_ready0), 32'd0);
    chk("abort angle_out", angle_out0, 32'd0);
    chk("abort quadrant", 32'(quadrant0), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    run0(tbl[0], "after_abort");

    // Held result while the consumer stalls; in_valid must be ignored meanwhile.
    angle_in0 = 32'h40A00000;
    in_valid0 = 1'b1;
    @(posedge clk); #1;
    angle_in0 = 32'h3F000000;
    lat = 1;
    while (!out_valid0 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall latency", lat, 5);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("stall%0d out_valid", c), 32'(out_valid0), 32'd1);
      chk($sformatf("stall%0d angle_out", c), angle_out0, 32'h3FA43F6B);
      chk($sformatf("stall%0d quadrant", c), 32'(quadrant0), 32'd3);
      chk($sformatf("stall%0d in_ready", c), 32'(in_ready0), 32'd0);
      @(posedge clk); #1;
    end
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;
    chk("release out_valid", 32'(out_valid0), 32'd0);
    chk("release busy (no bypass)", 32'(busy0), 32'd0);
    chk("hold angle_out", angle_out0, 32'h3FA43F6B);
    @(posedge clk); #1;
    in_valid0 = 1'b0;
    chk("next accept busy", 32'(busy0), 32'd1);
    @(posedge clk); #1;
    chk("next out_valid", 32'(out_valid0), 32'd1);
    chk("next angle_out", angle_out0, 32'h3F000000);
    chk("next quadrant", 32'(quadrant0), 32'd0);
    out_ready0 = 1'b1;
    @(posedge clk); #1;
    out_ready0 = 1'b0;

    // ADD_WAIT=2, back-to-back traffic against the model.
    in_valid2  = 1'b1;
    out_ready2 = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (i == 0) begin
        angle_in2 = 32'h40A00000;
      end else begin
        rr = (real'($urandom) / 4294967296.0) * 8.0 - 1.0;
        angle_in2 = r2f(rr);
      end
      fold(angle_in2, exp_res, exp_q, nadd);
      @(posedge clk); #1;
      lat = 1;
      while (!out_valid2 && lat < 60) begin
        @(posedge clk); #1;
        lat++;
      end
      chk($sformatf("rnd%0d %h latency", i, angle_in2), lat, 1 + 3 * nadd);
      chk($sformatf("rnd%0d %h angle_out", i, angle_in2), angle_out2, exp_res);
      chk($sformatf("rnd%0d %h quadrant", i, angle_in2), 32'(quadrant2), 32'(exp_q));
      @(posedge clk); #1;
    end
    in_valid2 = 1'b0;
    chk("w2 idle at end", 32'(busy2), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
